// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the mips_cpu_bus memory responder.
// Lane masks follow the CPU byteenable encoding, where 4'b0000 means a full word.
package mips_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } resp_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [3:0]  BE_FULL      = 4'b1111;

  function automatic logic [31:0] be_expand(input logic [3:0] byteenable);
    logic [3:0] be;
    be = (byteenable == 4'b0000) ? BE_FULL : byteenable;
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/mem_be_merge.sv
// Combinational byte-lane merge: enabled lanes come from the new word, the rest keep the old word.
module mem_be_merge
  import mips_bus_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_word_i,
  input  logic [3:0]  byteenable_i,
  output logic [31:0] merged_o
);

  logic [31:0] mask;

  assign mask     = be_expand(byteenable_i);
  assign merged_o = (new_word_i & mask) | (old_word_i & ~mask);

endmodule

// File: rtl/bus_mem_responder.sv
// Word-addressed RAM target for the mips_cpu_bus with programmable wait states.
// Accesses outside the window read as zero, drop writes and pulse bad_access.
module bus_mem_responder
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        bad_access
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

  typedef logic [DEPTH-1:0][31:0] mem_t;

  // RAM has no reset so contents survive a bus reset.
  mem_t mem_q = '0;

  resp_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] readdata_q, readdata_d;
  logic        bad_q, bad_d;

  logic          req, accept_cond, accept, in_range;
  logic [31:0]   offset, merged;
  logic [AW-1:0] idx;

  assign req      = read | write;
  assign offset   = address - BASE_ADDR;
  assign in_range = (address >= BASE_ADDR) && (offset < 32'(4 * DEPTH));
  assign idx      = offset[AW+1:2];

  mem_be_merge u_merge (
    .old_word_i   (mem_q[idx]),
    .new_word_i   (writedata),
    .byteenable_i (byteenable),
    .merged_o     (merged)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept_cond = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (WAIT_STATES == 0) begin
          accept_cond = 1'b1;
        end else if (req) begin
          state_d = WAIT;
          cnt_d   = WS_LOAD;
        end
      end
      WAIT: begin
        // A request dropped mid-wait is abandoned without committing.
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          accept_cond = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign waitrequest = ~reset | (req & ~accept_cond);
  assign accept      = reset & req & accept_cond;

  always_comb begin
    readdata_d = readdata_q;
    if (accept && read && !write) readdata_d = in_range ? mem_q[idx] : 32'h0;
    bad_d = accept & ~in_range;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      readdata_q <= '0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
      bad_q      <= bad_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && write && in_range) mem_q[idx] <= merged;
  end

  assign readdata   = readdata_q;
  assign bad_access = bad_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: two instances (0 and 3 wait states) checked against
// an array-based memory model with directed cases and randomized traffic.
module tb_bus_mem_responder;

  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int          DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [31:0] addr_s  [2];
  logic        rd_s    [2];
  logic        wr_s    [2];
  logic [31:0] wd_s    [2];
  logic [3:0]  be_s    [2];
  logic        wreq_s  [2];
  logic [31:0] rdata_s [2];
  logic        bad_s   [2];

  logic [31:0] mdl_mem [2][DEPTH];
  logic [31:0] mdl_rd  [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .reset(rst_n), .address(addr_s[0]), .read(rd_s[0]), .write(wr_s[0]),
    .waitrequest(wreq_s[0]), .writedata(wd_s[0]), .byteenable(be_s[0]),
    .readdata(rdata_s[0]), .bad_access(bad_s[0])
  );

  bus_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(3), .INIT_FILE("")) u_dut3 (
    .clk(clk), .reset(rst_n), .address(addr_s[1]), .read(rd_s[1]), .write(wr_s[1]),
    .waitrequest(wreq_s[1]), .writedata(wd_s[1]), .byteenable(be_s[1]),
    .readdata(rdata_s[1]), .bad_access(bad_s[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 4 * DEPTH);
  endfunction

  // One complete bus access; entered and left one time unit after a rising edge.
  task automatic access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input string tag);
    int ws;
    int w;
    ws = (d == 0) ? 0 : 3;
    addr_s[d] = a; wd_s[d] = wd; be_s[d] = be; rd_s[d] = rd; wr_s[d] = wr;
    for (int c = 0; c <= ws; c++) begin
      #1;
      check({tag, ".waitreq"}, {31'b0, wreq_s[d]}, {31'b0, (c < ws)});
      @(posedge clk); #1;
    end
    rd_s[d] = 1'b0; wr_s[d] = 1'b0;
    if (in_win(a)) begin
      w = int'((a - BASE) >> 2);
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (be == 4'b0000 || be[i]) mdl_mem[d][w][i*8 +: 8] = wd[i*8 +: 8];
      end else if (rd) begin
        mdl_rd[d] = mdl_mem[d][w];
      end
    end else if (rd && !wr) begin
      mdl_rd[d] = 32'h0;
    end
    check({tag, ".rdata"}, rdata_s[d], mdl_rd[d]);
    check({tag, ".bad"}, {31'b0, bad_s[d]}, {31'b0, !in_win(a)});
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      addr_s[d] = '0; rd_s[d] = 1'b0; wr_s[d] = 1'b0; wd_s[d] = '0; be_s[d] = '0;
      mdl_rd[d] = '0;
      for (int i = 0; i < DEPTH; i++) mdl_mem[d][i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst.waitreq", {31'b0, wreq_s[d]}, 32'd1);
      check("rst.rdata", rdata_s[d], 32'h0);
      check("rst.bad", {31'b0, bad_s[d]}, 32'd0);
    end
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check("idle.waitreq", {31'b0, wreq_s[d]}, 32'd0);
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++) begin
      access(d, 0, 1, BASE, 32'h3C08BFC0, 4'b0000, "w0");
      access(d, 1, 0, BASE, 32'h0, 4'b0000, "r0");
      access(d, 0, 1, BASE + 32'h2C, 32'h0000000F, 4'b1111, "w11");
      access(d, 0, 1, BASE + 32'h2C, 32'hAABBCCDD, 4'b0010, "w11be");
      access(d, 1, 0, BASE + 32'h2C, 32'h0, 4'b0000, "r11be");
      access(d, 0, 1, BASE + 32'h2D, 32'hAABBCCDD, 4'b0000, "w11full");
      access(d, 1, 0, BASE + 32'h2C, 32'h0, 4'b0000, "r11full");
      access(d, 1, 0, 32'h0, 32'h0, 4'b0000, "oow.r");
      @(posedge clk); #1;
      check("oow.bad_once", {31'b0, bad_s[d]}, 32'd0);
      access(d, 0, 1, BASE + 4 * DEPTH, 32'hDEADBEEF, 4'b0000, "oow.w_top");
      access(d, 0, 1, BASE - 4, 32'hDEADBEEF, 4'b0000, "oow.w_below");
      access(d, 1, 0, BASE, 32'h0, 4'b0000, "oow.r0");
      access(d, 1, 0, BASE + 4 * (DEPTH - 1), 32'h0, 4'b0000, "oow.rlast");
      access(d, 1, 1, BASE + 32'h30, 32'h4, 4'b0000, "rw12");
      access(d, 1, 0, BASE + 32'h30, 32'h0, 4'b0000, "r12");
    end

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 60; n++) begin
        int kind;
        int op;
        logic [31:0] a;
        kind = $urandom_range(0, 9);
        if (kind == 0) a = $urandom;
        else if (kind == 1) a = BASE + 4 * DEPTH + 32'($urandom_range(0, 15));
        else a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
        op = $urandom_range(0, 3);
        access(d, (op == 0 || op == 1 || op == 3), (op >= 2), a, $urandom,
               4'($urandom_range(0, 15)), "rand");
      end
    end

    // Reset arriving on the cycle a 3-wait-state write would have been accepted.
    addr_s[1] = BASE + 32'h14; wd_s[1] = 32'h12345678; be_s[1] = 4'b0000; wr_s[1] = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst.waitreq3", {31'b0, wreq_s[1]}, 32'd1);
    check("midrst.waitreq0", {31'b0, wreq_s[0]}, 32'd1);
    @(posedge clk); #1;
    check("midrst.waitreq_hold", {31'b0, wreq_s[1]}, 32'd1);
    check("midrst.rdata", rdata_s[1], 32'h0);
    check("midrst.bad", {31'b0, bad_s[1]}, 32'd0);
    @(posedge clk); #1;
    wr_s[1] = 1'b0;
    rst_n = 1'b1;
    mdl_rd[0] = 32'h0;
    mdl_rd[1] = 32'h0;
    #1;
    check("midrst.idle", {31'b0, wreq_s[1]}, 32'd0);
    check("midrst.rdata0", rdata_s[0], 32'h0);
    @(posedge clk); #1;
    access(1, 1, 0, BASE + 32'h14, 32'h0, 4'b0000, "midrst.nocommit");
    access(1, 1, 0, BASE + 32'h30, 32'h0, 4'b0000, "midrst.preserved");
    access(0, 1, 0, BASE + 32'h30, 32'h0, 4'b0000, "midrst.preserved0");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
